hi_low_game_ctrl: RTL and testbench

//  Sequencing controller for the Hi-Low guessing game. Debounces the two pushbuttons and latches
//  a scrambled target from seedSwitch. Runs the game FSM and evaluates each guess as high, low or win.

---
 rtl/hi_low_pkg.sv | 20 ++
 rtl/btn_pulse.sv | 27 ++
 rtl/hi_low_game_ctrl.sv | 88 ++++++++
 tb/tb_hi_low_game_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hi_low_pkg.sv
// hi_low_pkg: state/result codes and target scramble shared by the Hi-Low game controller
package hi_low_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PLAY  = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_HIGH = 2'b01;
    localparam logic [1:0] RES_LOW  = 2'b10;
    localparam logic [1:0] RES_WIN  = 2'b11;
    // One LFSR step; a zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [7:0] scramble(input logic [7:0] seed);
        logic [7:0] s;
        s = (seed == 8'd0) ? 8'd1 : seed;
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
endpackage

// File: rtl/btn_pulse.sv
// btn_pulse: synchronises an active-low button and emits one pulse per debounced press
module btn_pulse #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    // Counter saturates at DB_CYCLES so a held button never retriggers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= ~button;
            s2    <= s1;
            cnt   <= !s2 ? '0 : (cnt == CW'(DB_CYCLES)) ? cnt : cnt + 1'b1;
            pulse <= s2 && (cnt == CW'(DB_CYCLES - 1));
        end
    end
endmodule

// File: rtl/hi_low_game_ctrl.sv
// hi_low_game_ctrl: Hi-Low game FSM with debounced buttons, scrambled target and guess counter
module hi_low_game_ctrl
    import hi_low_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_GUESSES = 8,
    parameter int DB_CYCLES   = 500000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   randBut,
    input  logic                   hiLowBut,
    input  logic                   playSwitch,
    input  logic [WIDTH-1:0]       seedSwitch,
    input  logic [WIDTH-1:0]       guessSwitch,
    output logic [WIDTH-1:0]       target,
    output logic                   showTarget,
    output logic [1:0]             result,
    output logic [3:0]             guessesLeft,
    output logic [MAX_GUESSES-1:0] greenLEDs,
    output logic [2:0]             state
);
    state_t st;
    logic rand_pulse, guess_pulse;
    logic [WIDTH-1:0] new_target;
    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_rand (
        .clk(clk), .reset_n(reset_n), .button(randBut), .pulse(rand_pulse)
    );
    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_guess (
        .clk(clk), .reset_n(reset_n), .button(hiLowBut), .pulse(guess_pulse)
    );
    assign new_target = WIDTH'(scramble(8'(seedSwitch)));
    assign state      = st;
    for (genvar i = 0; i < MAX_GUESSES; i++) begin : g_led
        assign greenLEDs[i] = 32'(guessesLeft) > i;
    end
    // Dropping playSwitch aborts from any active state ahead of any pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= S_IDLE;
            target      <= '0;
            result      <= RES_NONE;
            guessesLeft <= '0;
            showTarget  <= 1'b0;
        end else if (st != S_IDLE && !playSwitch) begin
            st          <= S_IDLE;
            result      <= RES_NONE;
            guessesLeft <= '0;
            showTarget  <= 1'b0;
        end else begin
            case (st)
                S_IDLE: if (rand_pulse) begin
                    target <= new_target;
                    result <= RES_NONE;
                    st     <= S_ARMED;
                end
                S_ARMED: if (rand_pulse) begin
                    target <= new_target;
                end else begin
                    guessesLeft <= 4'(MAX_GUESSES);
                    st          <= S_PLAY;
                end
                S_PLAY: if (guess_pulse) begin
                    if (guessSwitch == target) begin
                        result     <= RES_WIN;
                        showTarget <= 1'b1;
                        st         <= S_WIN;
                    end else begin
                        result <= (guessSwitch > target) ? RES_HIGH : RES_LOW;
                        if (guessesLeft != 4'd0) guessesLeft <= guessesLeft - 4'd1;
                        if (guessesLeft <= 4'd1) begin
                            showTarget <= 1'b1;
                            st         <= S_LOSE;
                        end
                    end
                end
                S_WIN, S_LOSE: if (rand_pulse) begin
                    target      <= new_target;
                    result      <= RES_NONE;
                    guessesLeft <= '0;
                    showTarget  <= 1'b0;
                    st          <= S_ARMED;
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hi_low_game_ctrl.sv
// tb_hi_low_game_ctrl: directed and randomized checks against an event-level game model
module tb_hi_low_game_ctrl;
    localparam int DB = 4;
    logic clk = 0, reset_n = 0, randBut = 1, hiLowBut = 1, playSwitch = 0;
    logic [7:0] seedSwitch = 0, guessSwitch = 0, target;
    logic showTarget;
    logic [1:0] result;
    logic [3:0] guessesLeft;
    logic [7:0] greenLEDs;
    logic [2:0] state;
    int n_chk = 0, n_fail = 0;
    int m_state = 0, m_left = 0;
    logic [7:0] m_tgt = 0;
    logic [1:0] m_res = 0;
    bit m_play = 0;

    hi_low_game_ctrl #(.WIDTH(8), .MAX_GUESSES(8), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .randBut(randBut), .hiLowBut(hiLowBut),
        .playSwitch(playSwitch), .seedSwitch(seedSwitch), .guessSwitch(guessSwitch),
        .target(target), .showTarget(showTarget), .result(result),
        .guessesLeft(guessesLeft), .greenLEDs(greenLEDs), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: game state changes per completed button action.
    function automatic logic [7:0] scr(input logic [7:0] sd);
        int s, fb;
        s  = (sd == 0) ? 1 : sd;
        fb = ((s >> 7) + (s >> 5) + (s >> 4) + (s >> 3)) % 2;
        return 8'(((s * 2) % 256) + fb);
    endfunction

    task automatic m_reset();
        m_state = 0; m_left = 0; m_tgt = 0; m_res = 0;
    endtask

    task automatic m_rand(input logic [7:0] sd);
        if (m_state == 0 || m_state >= 3) begin
            m_tgt   = scr(sd);
            m_res   = 0;
            m_left  = m_play ? 8 : 0;
            m_state = m_play ? 2 : 0;
        end
    endtask

    task automatic m_guess(input logic [7:0] g);
        if (m_state == 2) begin
            if (g == m_tgt) begin
                m_res = 3; m_state = 3;
            end else begin
                m_res = (g > m_tgt) ? 1 : 2;
                m_left = m_left - 1;
                if (m_left == 0) m_state = 4;
            end
        end
    endtask

    task automatic m_set_play(input bit v);
        m_play = v;
        if (!v && m_state != 0) begin
            m_state = 0; m_res = 0; m_left = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".target"}, 32'(target), 32'(m_tgt));
        check({tag, ".result"}, 32'(result), 32'(m_res));
        check({tag, ".left"}, 32'(guessesLeft), 32'(m_left));
        check({tag, ".leds"}, 32'(greenLEDs), (32'd1 << m_left) - 1);
        check({tag, ".show"}, 32'(showTarget), 32'(m_state >= 3));
    endtask

    task automatic press_rand(input logic [7:0] sd);
        seedSwitch = sd; randBut = 0; tick(DB + 6);
        randBut = 1; tick(4);
        m_rand(sd);
    endtask

    task automatic press_guess(input logic [7:0] g);
        guessSwitch = g; hiLowBut = 0; tick(DB + 6);
        hiLowBut = 1; tick(4);
        m_guess(g);
    endtask

    initial begin
        int lat;
        #1;
        compare_all("reset");
        tick(3);
        reset_n = 1;
        tick(2);
        compare_all("post_reset");
        // 1: scramble and the transient ARMED state
        seedSwitch = 8'h01; randBut = 0; lat = 0;
        while (state == 3'd0 && lat < 20) begin
            tick(1); lat++;
        end
        check("t1.armed", 32'(state), 32'd1);
        check("t1.latency_ok", 32'(lat <= DB + 4), 32'd1);
        randBut = 1; tick(6);
        m_rand(8'h01);
        check("t1.tgt01", 32'(target), 32'h02);
        compare_all("t1a");
        press_rand(8'h00);
        check("t1.tgt00", 32'(target), 32'h02);
        press_rand(8'h80);
        check("t1.tgt80", 32'(target), 32'h01);
        compare_all("t1c");
        // 2: high, low, win
        playSwitch = 1; m_set_play(1); tick(2);
        press_rand(8'h01);
        compare_all("t2.play");
        press_guess(8'h05);
        check("t2.high", 32'(result), 32'd1);
        check("t2.left7", 32'(guessesLeft), 32'd7);
        press_guess(8'h01);
        check("t2.low", 32'(result), 32'd2);
        check("t2.left6", 32'(guessesLeft), 32'd6);
        press_guess(8'h02);
        check("t2.win", 32'(state), 32'd3);
        check("t2.show", 32'(showTarget), 32'd1);
        compare_all("t2");
        // 3: run out of guesses
        press_rand(8'h01);
        for (int i = 0; i < 8; i++) begin
            press_guess(8'hFF);
            check("t3.leds", 32'(greenLEDs), 32'((8'hFF >> (i + 1))));
            compare_all("t3");
        end
        check("t3.lose", 32'(state), 32'd4);
        press_guess(8'hFF);
        compare_all("t3.extra");
        // 4: bounce then long hold gives one evaluation
        press_rand(8'h01);
        guessSwitch = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            hiLowBut = ~hiLowBut; tick(2);
        end
        hiLowBut = 0; tick(100);
        hiLowBut = 1; tick(4);
        m_guess(8'hFF);
        check("t4.once", 32'(guessesLeft), 32'd7);
        compare_all("t4");
        // 5: abort coinciding with a guess pulse
        guessSwitch = 8'hFF; hiLowBut = 0; tick(DB + 2);
        playSwitch = 0; tick(1);
        hiLowBut = 1; tick(4);
        m_set_play(0);
        check("t5.tgt", 32'(target), 32'h02);
        compare_all("t5");
        // 6a: reset mid-debounce
        seedSwitch = 8'h55; randBut = 0; tick(3);
        #2 reset_n = 0;
        #1 m_reset();
        compare_all("t6a.async");
        randBut = 1;
        @(negedge clk) reset_n = 1;
        tick(15);
        compare_all("t6a.after");
        // 6b: reset mid-PLAY
        playSwitch = 1; m_set_play(1); tick(2);
        press_rand(8'h33);
        press_guess(8'h00);
        compare_all("t6b.pre");
        #2 reset_n = 0;
        #1 m_reset();
        compare_all("t6b.async");
        @(negedge clk) reset_n = 1;
        tick(10);
        compare_all("t6b.after");
        // randomized actions
        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) press_rand(8'($urandom));
            else if (r < 8) press_guess(($urandom_range(0, 1) == 1) ? m_tgt : 8'($urandom));
            else begin
                playSwitch = ~playSwitch; tick(3);
                m_set_play(playSwitch);
            end
            compare_all("rnd");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
